uart_tx_serializer: RTL and testbench



---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_baud_counter.sv | 31 +++
 rtl/uart_tx_serializer.sv | 123 ++++++++++++
 tb/tb_uart_tx_serializer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default line rate and idle level.
// Imported by the transmitter and, later, the matching receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int CLK_HZ       = 50_000_000;
  localparam int BAUD         = 115_200;
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// Shared between the UART transmitter and receiver.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int                 CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign bit_end = (count == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: accepts one word per tx_start in IDLE and sends it
// LSB-first as start / DATA_BITS data / STOP_BITS stop, all outputs registered.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  import uart_pkg::*;

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  uart_state_t          state, state_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic [3:0]           idx_q, idx_n;
  logic                 tx_n, busy_n, done_n;
  logic                 bit_end;
  logic                 baud_clear;

  // Held clear while idle; every later state is entered on a wrap, so the
  // counter already starts each state at zero.
  assign baud_clear = (state == IDLE);

  uart_baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clock   (clock),
    .reset   (reset),
    .clear   (baud_clear),
    .bit_end (bit_end)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx      <= IDLE_LEVEL;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_n;
      shift_q <= shift_n;
      idx_q   <= idx_n;
      tx      <= tx_n;
      tx_busy <= busy_n;
      tx_done <= done_n;
    end
  end

  // The line level is computed one cycle ahead so tx comes straight off a flop.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case
    // leaves one unassigned and no latch is inferred.
    state_n = state;
    shift_n = shift_q;
    idx_n   = idx_q;
    tx_n    = tx;
    busy_n  = tx_busy;
    done_n  = 1'b0;

    unique case (state)
      IDLE: begin
        tx_n   = IDLE_LEVEL;
        busy_n = 1'b0;
        idx_n  = '0;
        if (tx_start) begin
          shift_n = tx_data;
          state_n = START;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
        end
      end

      START: begin
        if (bit_end) begin
          state_n = DATA;
          idx_n   = '0;
          tx_n    = shift_q[0];
        end
      end

      DATA: begin
        if (bit_end) begin
          shift_n = shift_q >> 1;
          if (idx_q == LAST_DATA) begin
            state_n = STOP;
            idx_n   = '0;
            tx_n    = IDLE_LEVEL;
          end else begin
            idx_n = idx_q + 4'd1;
            tx_n  = shift_q[1];
          end
        end
      end

      STOP: begin
        if (bit_end) begin
          if (idx_q == LAST_STOP) begin
            state_n = IDLE;
            idx_n   = '0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            idx_n = idx_q + 4'd1;
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: 8N1 at 4 clocks/bit, plus a
// 2-stop-bit instance at 3 clocks/bit; expected line drawn from frame rules.
module tb_uart_tx_serializer;

  logic       clock;
  logic       reset;
  logic       tx_start, tx_start2;
  logic [7:0] tx_data, tx_data2;
  logic       tx, tx_busy, tx_done;
  logic       tx2, tx_busy2, tx_done2;

  int checks;
  int failures;

  uart_tx_serializer #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1)) dut (
    .clock    (clock),
    .reset    (reset),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  uart_tx_serializer #(.CLKS_PER_BIT(3), .DATA_BITS(8), .STOP_BITS(2)) dut2 (
    .clock    (clock),
    .reset    (reset),
    .tx_start (tx_start2),
    .tx_data  (tx_data2),
    .tx       (tx2),
    .tx_busy  (tx_busy2),
    .tx_done  (tx_done2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Line level i cycles after the acceptance edge: start bit, LSB-first data, then stop.
  function automatic logic exp_tx(input logic [7:0] d, input int i, input int cpb, input int db);
    int p;
    p = i / cpb;
    if (p == 0) return 1'b0;
    if (p <= db) return d[p-1];
    return 1'b1;
  endfunction

  task automatic start_frame(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clock);
    tx_start = 1'b0;
  endtask

  // Entered one cycle after acceptance; returns in the tx_done cycle.
  task automatic check_frame(input string name, input logic [7:0] d, input bit noisy);
    logic [2:0] exp;
    for (int c = 1; c <= 40; c++) begin
      exp = {exp_tx(d, c - 1, 4, 8), 1'b1, 1'b0};
      checks++;
      if ({tx, tx_busy, tx_done} !== exp) begin
        failures++;
        $display("FAIL %s cycle %0d data=%h: {tx,busy,done} got %b expected %b",
                 name, c, d, {tx, tx_busy, tx_done}, exp);
      end
      if (noisy) begin
        tx_data  = (c == 15) ? 8'hFF : 8'($urandom);
        tx_start = (c == 15);
      end
      @(negedge clock);
    end
    tx_start = 1'b0;
    checks++;
    if ({tx, tx_busy, tx_done} !== 3'b101) begin
      failures++;
      $display("FAIL %s done-cycle data=%h: {tx,busy,done} got %b expected 101",
               name, d, {tx, tx_busy, tx_done});
    end
  endtask

  task automatic check_idle(input string name, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clock);
      checks++;
      if ({tx, tx_busy, tx_done} !== 3'b100) begin
        failures++;
        $display("FAIL %s idle cycle %0d: {tx,busy,done} got %b expected 100",
                 name, c, {tx, tx_busy, tx_done});
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tx_start = 1'b0; tx_data = 8'h00;
    tx_start2 = 1'b0; tx_data2 = 8'h00;
    repeat (2) @(negedge clock);
    checks++;
    if ({tx, tx_busy, tx_done, tx2, tx_busy2, tx_done2} !== 6'b100100) begin
      failures++;
      $display("FAIL reset_state: got %b expected 100100",
               {tx, tx_busy, tx_done, tx2, tx_busy2, tx_done2});
    end
    reset = 1'b0;
    check_idle("after_reset", 3);
  endtask

  task automatic test_single_byte();
    start_frame(8'hA5);
    check_frame("single_a5", 8'hA5, 1'b0);
    check_idle("single_tail", 3);
  endtask

  task automatic test_ignored_request();
    start_frame(8'hA5);
    check_frame("ignored_req", 8'hA5, 1'b1);
    check_idle("no_extra_frame", 12);
  endtask

  task automatic test_back_to_back();
    start_frame(8'h5A);
    check_frame("b2b_first", 8'h5A, 1'b0);
    start_frame(8'h00);
    check_frame("b2b_second", 8'h00, 1'b0);
    start_frame(8'hFF);
    check_frame("b2b_third", 8'hFF, 1'b0);
    check_idle("b2b_tail", 2);
  endtask

  task automatic test_reset_mid_data();
    start_frame(8'hC3);
    // Cycles 17..20 carry data bit 3 (a 0 for C3).
    repeat (17) @(negedge clock);
    checks++;
    if ({tx, tx_busy} !== 2'b01) begin
      failures++;
      $display("FAIL mid_data_before_reset: {tx,busy} got %b expected 01", {tx, tx_busy});
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({tx, tx_busy, tx_done} !== 3'b100) begin
      failures++;
      $display("FAIL async_reset_immediate: {tx,busy,done} got %b expected 100",
               {tx, tx_busy, tx_done});
    end
    #1 reset = 1'b0;
    check_idle("abandoned_frame", 6);
    @(negedge clock);
    start_frame(8'h3C);
    check_frame("after_reset_3c", 8'h3C, 1'b0);
    check_idle("after_reset_tail", 2);
  endtask

  task automatic test_two_stop();
    logic [2:0] exp;
    tx_data2  = 8'h81;
    tx_start2 = 1'b1;
    @(negedge clock);
    tx_start2 = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      exp = {exp_tx(8'h81, c - 1, 3, 8), 1'b1, 1'b0};
      checks++;
      if ({tx2, tx_busy2, tx_done2} !== exp) begin
        failures++;
        $display("FAIL two_stop cycle %0d: {tx,busy,done} got %b expected %b",
                 c, {tx2, tx_busy2, tx_done2}, exp);
      end
      @(negedge clock);
    end
    checks++;
    if ({tx2, tx_busy2, tx_done2} !== 3'b101) begin
      failures++;
      $display("FAIL two_stop done-cycle: {tx,busy,done} got %b expected 101",
               {tx2, tx_busy2, tx_done2});
    end
    @(negedge clock);
    checks++;
    if ({tx2, tx_busy2, tx_done2} !== 3'b100) begin
      failures++;
      $display("FAIL two_stop after: {tx,busy,done} got %b expected 100",
               {tx2, tx_busy2, tx_done2});
    end
  endtask

  // A paced producer sending 0x00..0x0A twice with a pause between passes.
  task automatic test_controller_sequence();
    for (int pass = 0; pass < 2; pass++) begin
      for (int w = 0; w <= 10; w++) begin
        start_frame(8'(w));
        check_frame("ctrl_seq", 8'(w), 1'b0);
      end
      check_idle("ctrl_pause", 8);
    end
  endtask

  task automatic test_random_frames();
    logic [7:0] d;
    int         gap;
    for (int n = 0; n < 12; n++) begin
      d   = 8'($urandom);
      gap = $urandom_range(0, 3);
      start_frame(d);
      check_frame("random", d, n[0]);
      if (gap > 0) check_idle("random_gap", gap);
    end
    check_idle("random_tail", 2);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single_byte();
    test_ignored_request();
    test_back_to_back();
    test_reset_mid_data();
    test_two_stop();
    test_controller_sequence();
    test_random_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
